tt_tbuf_drive_arb: RTL

Arbitrates ownership of one shared tristate net between N_REQ requesters. Each requester has its own positive-enable tristate buffer primitive; polarity conversion happens downstream. Grants are round-robin, with a guaranteed dead-time between one driver releasing and the next enabling (break-before-make), so two buffers never drive the net at once. Sits in the mux/control domain, one instance per shared pad/net.

---
 rtl/tt_tbuf_drive_arb.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/tt_tbuf_drive_arb.sv
// Round-robin, break-before-make ownership arbiter for one shared tristate net.
// Optional hold-time preemption is enabled by defining TT_TBUF_ARB_TIMEOUT_EN.
module tt_tbuf_drive_arb #(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int HOLD_MAX   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] t_en,
    output logic             busy,
    output logic             preempt
);

    localparam int              IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [3:0]      GAP_LOAD = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [IDX_W-1:0]   last_r;
    logic [IDX_W-1:0]   pick_s;
    logic [IDX_W-1:0]   scan_idx_s;
    int                 scan_sum_s;
    logic               pick_valid_s;
    logic               req_own_s;
    logic               timeout_s;
    logic [3:0]         gap_cnt_r;
    logic [N_REQ-1:0]   grant_r;
    logic [N_REQ-1:0]   t_en_r;
    logic [N_REQ-1:0]   grant_next_s;
    logic [N_REQ-1:0]   t_en_next_s;
    logic               busy_r;
    logic               preempt_r;
    logic               busy_next_s;
    logic               preempt_next_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin scan: walk offsets from farthest to nearest so the nearest request above last_r wins.
    always_comb begin
        pick_s       = last_r;
        pick_valid_s = 1'b0;
        scan_sum_s   = 0;
        scan_idx_s   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            scan_sum_s   = int'(last_r) + i;
            scan_sum_s   = (scan_sum_s >= N_REQ) ? (scan_sum_s - N_REQ) : scan_sum_s;
            scan_idx_s   = IDX_W'(scan_sum_s);
            pick_s       = req[scan_idx_s] ? scan_idx_s : pick_s;
            pick_valid_s = pick_valid_s | req[scan_idx_s];
        end
    end

    assign req_own_s = req[last_r];

`ifdef TT_TBUF_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt_r;

    // Hold counter: zero outside DRIVE, so it starts from 0 on every DRIVE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else if (state_r != DRIVE) begin
            hold_cnt_r <= 8'd0;
        end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end
    end

    assign timeout_s = (state_r == DRIVE) && (hold_cnt_r == HOLD_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    next_state_s = SETUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                if (req_own_s) begin
                    next_state_s = DRIVE;
                end else begin
                    next_state_s = GAP;
                end
            end
            DRIVE: begin
                if (!req_own_s || timeout_s) begin
                    next_state_s = GAP;
                end else begin
                    next_state_s = DRIVE;
                end
            end
            GAP: begin
                if (gap_cnt_r == 4'd0) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GAP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state; SETUP is only reached from IDLE, so it uses the fresh pick.
    always_comb begin
        grant_next_s   = '0;
        t_en_next_s    = '0;
        busy_next_s    = (next_state_s != IDLE);
        preempt_next_s = timeout_s && req_own_s;
        case (next_state_s)
            SETUP: begin
                grant_next_s = onehot(pick_s);
            end
            DRIVE: begin
                grant_next_s = onehot(last_r);
                t_en_next_s  = onehot(last_r);
            end
            default: begin
                grant_next_s = '0;
                t_en_next_s  = '0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r   <= '0;
            t_en_r    <= '0;
            busy_r    <= 1'b0;
            preempt_r <= 1'b0;
        end else begin
            grant_r   <= grant_next_s;
            t_en_r    <= t_en_next_s;
            busy_r    <= busy_next_s;
            preempt_r <= preempt_next_s;
        end
    end

    // The last winner doubles as the current owner index for SETUP/DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= LAST_RST;
        end else if ((state_r == IDLE) && pick_valid_s) begin
            last_r <= pick_s;
        end else begin
            last_r <= last_r;
        end
    end

    // Dead-time counter: parked at its load value outside GAP, counts down inside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_r <= 4'd0;
        end else if (state_r != GAP) begin
            gap_cnt_r <= GAP_LOAD;
        end else if (gap_cnt_r != 4'd0) begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    assign grant   = grant_r;
    assign t_en    = t_en_r;
    assign busy    = busy_r;
    assign preempt = preempt_r;

endmodule
